fp_cmp_arb: RTL and testbench
=============================

FP_CMP_ARB -- requirements
Module: fp_cmp_arb

Interface
REQ-001 Parameter FP_FORMAT, default FP32: operand format passed to the internal fp_cmp instance; FP_WIDTH = fp_width(FP_FORMAT).
REQ-002 Parameter NUM_REQ, default 2, legal range 2..8: number of requesters sharing one comparator; IDW = max(1, $clog2(NUM_REQ)).
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-006 req_ready_o  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-007 req_a_i  input  NUM_REQ*FP_WIDTH  operand A, requester i at slice i.
REQ-008 req_b_i  input  NUM_REQ*FP_WIDTH  operand B, requester i at slice i.
REQ-009 req_op_i  input  NUM_REQ*2  operation: 00 FLE, 01 FLT, 10 FEQ, 11 reserved.
REQ-010 resp_valid_o  output  1  response held in output register.
REQ-011 resp_ready_i  input  1  consumer accepts response.
REQ-012 resp_id_o  output  IDW  index of requester that issued the response.
REQ-013 resp_result_o  output  1  comparison result.
REQ-014 resp_flags_o  output  status_t  exception flags of the comparison.

Function
REQ-015 Block SHALL instantiate exactly one fp_cmp; all requesters share it.
REQ-016 Output register SHALL be a single-entry buffer with states EMPTY (resp_valid_o=0) and FULL (resp_valid_o=1).
REQ-017 can_accept SHALL equal (~resp_valid_o | resp_ready_i); accepts allowed in EMPTY, or in FULL when the same-cycle pop occurs.
REQ-018 Grant SHALL be round-robin: the lowest index at or after pointer ptr with req_valid_i set; req_ready_o[g]=can_accept for winner g, 0 for all others.
REQ-019 Handshake fires for requester i when req_valid_i[i] & req_ready_o[i]; at most one fire per cycle.
REQ-020 On fire, ptr SHALL become (g+1) mod NUM_REQ; without a fire, ptr SHALL hold.
REQ-021 On fire, the comparator SHALL receive requester g's operands with start_i=1 and eq_en_i=(op==10); otherwise start_i=0.
REQ-022 On fire, the next edge SHALL load resp_id_o=g and resp_valid_o=1.
  - resp_result_o = le_o for FLE, lt_o for FLT, eq_o for FEQ.
  - resp_flags_o = comparator flags_o.
  - Latency is exactly 1 cycle from fire to resp_valid_o.
REQ-023 Op 11 SHALL still be accepted and respond with resp_result_o=0 and all flags 0.
REQ-024 Pop (resp_valid_o & resp_ready_i) without a fire SHALL clear resp_valid_o; pop with a fire SHALL reload the register (FULL->FULL); sustained throughput is one op per cycle.
REQ-025 In FULL with resp_ready_i=0, resp_* SHALL hold stable and all req_ready_o SHALL be 0.
REQ-026 req_ready_o SHALL NOT depend on resp_valid_o's next value; its only inputs are req_valid_i, ptr, resp_valid_o and resp_ready_i.
REQ-027 Requesters SHALL hold valid and payload until ready; a dropped valid without fire is legal and leaves ptr unchanged.
REQ-028 Resulting NaN semantics:
  - FLT/FLE with any NaN -> result 0, NV=1.
  - FEQ with qNaN -> result 0, NV=0.
  - FEQ with sNaN -> NV=1.
  - +0 and -0 compare equal.

Reset
REQ-029 While rst_i=1, regardless of clock, the block SHALL hold resp_valid_o=0, resp_id_o=0, resp_result_o=0, resp_flags_o=0 and ptr=0.
REQ-030 While rst_i=1, req_ready_o SHALL be all 0.
REQ-031 Reset mid-operation SHALL discard any held response; no response is emitted for a request fired in the reset cycle.
REQ-032 First fire after reset deassertion SHALL give priority to requester 0.

Verification
REQ-033 Requester 0 FLT(0x3F800000, 0x40000000), resp_ready_i=1 -> next cycle resp_valid_o=1, id=0, result=1, flags=0.
REQ-034 Both requesters valid continuously with resp_ready_i=1 -> grants alternate 0,1,0,1; one response per cycle with matching ids.
REQ-035 FEQ(0x7FC00000, 0x3F800000) -> result 0, NV=0; FEQ(0x7F800001, 0x3F800000) -> result 0, NV=1; FLE(0x7FC00000, 0x3F800000) -> result 0, NV=1.
REQ-036 FEQ(0x00000000, 0x80000000) -> result 1; FLE(0xBF800000, 0x3F800000) -> result 1.
REQ-037 Response held with resp_ready_i=0 for 3 cycles -> resp_* stable, req_ready_o=0; resp_ready_i=1 with a request pending -> pop and reload in the same cycle.
REQ-038 rst_i asserted asynchronously while FULL -> resp_valid_o=0 immediately; after release, requester 0 wins a simultaneous 0/1 request.

Source files
------------

// File: rtl/fp_cmp_arb.sv
// fp_cmp_arb: round-robin arbiter sharing one floating-point comparator
// among NUM_REQ requesters, with a single-entry registered response.
package fp_cmp_arb_pkg;
   typedef enum logic [1:0] {FP32, FP64, FP16} fp_format_e;
   typedef struct packed {logic nv; logic dz; logic of; logic uf; logic nx;} status_t;
   function automatic int fp_width(fp_format_e f);
      return (f == FP64) ? 64 : (f == FP16) ? 16 : 32;
   endfunction
   function automatic int fp_exp(fp_format_e f);
      return (f == FP64) ? 11 : (f == FP16) ? 5 : 8;
   endfunction
endpackage

module fp_cmp
   import fp_cmp_arb_pkg::*;
#(
   parameter fp_format_e FP_FORMAT = FP32,
   localparam int W = fp_width(FP_FORMAT),
   localparam int E = fp_exp(FP_FORMAT)
) (
   input  logic         start_i,
   input  logic         eq_en_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic         le_o,
   output logic         lt_o,
   output logic         eq_o,
   output status_t      flags_o
);
   localparam int M = W - 1 - E;
   logic a_nan, b_nan, a_snan, b_snan, any_nan, zero, lt_raw, eq_raw, nv;
   assign a_nan   = &a_i[W-2:M] & |a_i[M-1:0];
   assign b_nan   = &b_i[W-2:M] & |b_i[M-1:0];
   assign a_snan  = a_nan & ~a_i[M-1];
   assign b_snan  = b_nan & ~b_i[M-1];
   assign any_nan = a_nan | b_nan;
   // +0 and -0 share a zero magnitude and must compare equal
   assign zero    = ~|{a_i[W-2:0], b_i[W-2:0]};
   assign eq_raw  = (a_i == b_i) | zero;
   assign lt_raw  = (a_i[W-1] != b_i[W-1]) ? a_i[W-1] & ~zero :
                    a_i[W-1] ? (b_i[W-2:0] < a_i[W-2:0]) : (a_i[W-2:0] < b_i[W-2:0]);
   assign eq_o    = start_i & ~any_nan & eq_raw;
   assign lt_o    = start_i & ~any_nan & lt_raw;
   assign le_o    = start_i & ~any_nan & (lt_raw | eq_raw);
   assign nv      = start_i & (eq_en_i ? (a_snan | b_snan) : any_nan);
   assign flags_o = status_t'({nv, 4'b0000});
endmodule

module fp_cmp_arb
   import fp_cmp_arb_pkg::*;
#(
   parameter fp_format_e FP_FORMAT = FP32,
   parameter int NUM_REQ = 2,
   localparam int FP_WIDTH = fp_width(FP_FORMAT),
   localparam int IDW = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NUM_REQ-1:0]           req_valid_i,
   output logic [NUM_REQ-1:0]           req_ready_o,
   input  logic [NUM_REQ*FP_WIDTH-1:0]  req_a_i,
   input  logic [NUM_REQ*FP_WIDTH-1:0]  req_b_i,
   input  logic [NUM_REQ*2-1:0]         req_op_i,
   output logic                         resp_valid_o,
   input  logic                         resp_ready_i,
   output logic [IDW-1:0]               resp_id_o,
   output logic                         resp_result_o,
   output status_t                      resp_flags_o
);
   typedef enum logic {EMPTY, FULL} state_e;
   state_e state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, g;
   logic res_q, res_d, hit, can_accept, fire, le, lt, eq;
   logic [1:0] op_g;
   status_t flg_q, flg_d, flags;

   always_comb begin
      hit = 1'b0;
      g   = '0;
      for (int k = 0; k < NUM_REQ; k++)
         if (!hit && req_valid_i[(int'(ptr_q) + k) % NUM_REQ]) begin
            hit = 1'b1;
            g   = IDW'((int'(ptr_q) + k) % NUM_REQ);
         end
   end

   assign can_accept  = ~resp_valid_o | resp_ready_i;
   assign fire        = hit & can_accept & ~rst_i;
   assign req_ready_o = fire ? {{(NUM_REQ-1){1'b0}}, 1'b1} << g : '0;
   assign op_g        = req_op_i[int'(g)*2 +: 2];

   fp_cmp #(.FP_FORMAT(FP_FORMAT)) u_cmp (
      .start_i (fire),
      .eq_en_i (op_g == 2'b10),
      .a_i     (req_a_i[int'(g)*FP_WIDTH +: FP_WIDTH]),
      .b_i     (req_b_i[int'(g)*FP_WIDTH +: FP_WIDTH]),
      .le_o    (le),
      .lt_o    (lt),
      .eq_o    (eq),
      .flags_o (flags)
   );

   always_comb begin
      state_d = (fire | (resp_valid_o & ~resp_ready_i)) ? FULL : EMPTY;
      ptr_d   = fire ? IDW'((int'(g) + 1) % NUM_REQ) : ptr_q;
      id_d    = fire ? g : id_q;
      res_d   = ~fire ? res_q : (op_g == 2'b00) ? le : (op_g == 2'b01) ? lt : (op_g == 2'b10) ? eq : 1'b0;
      flg_d   = ~fire ? flg_q : (op_g == 2'b11) ? status_t'('0) : flags;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         ptr_q   <= '0;
         id_q    <= '0;
         res_q   <= 1'b0;
         flg_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         res_q   <= res_d;
         flg_q   <= flg_d;
      end
   end

   assign resp_valid_o  = (state_q == FULL);
   assign resp_id_o     = id_q;
   assign resp_result_o = res_q;
   assign resp_flags_o  = flg_q;
endmodule

// File: tb/tb_fp_cmp_arb.sv
// tb_fp_cmp_arb: scoreboard bench for the two-requester FP32 compare arbiter.
module tb_fp_cmp_arb;
   typedef struct {logic id; logic res; logic [4:0] flg;} exp_t;

   logic        clk = 1'b0, rst = 1'b1, resp_ready = 1'b1;
   logic [1:0]  req_valid = '0, req_ready;
   logic [63:0] req_a = '0, req_b = '0;
   logic [3:0]  req_op = '0;
   logic        resp_valid, resp_id, resp_result;
   logic [4:0]  resp_flags;

   int   checks = 0, errors = 0;
   exp_t q[$];
   logic m_vld = 1'b0, m_ptr = 1'b0;
   logic exp_res[2], exp_nv[2];

   always #5 clk = ~clk;

   fp_cmp_arb dut (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_a_i(req_a), .req_b_i(req_b), .req_op_i(req_op),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_id_o(resp_id),
      .resp_result_o(resp_result), .resp_flags_o(resp_flags)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic r, input logic nv);
      req_valid[i]      = v;
      req_op[i*2 +: 2]  = op;
      req_a[i*32 +: 32] = a;
      req_b[i*32 +: 32] = b;
      exp_res[i]        = r;
      exp_nv[i]         = nv;
   endtask

   // Called right after a falling edge with inputs already driven.
   task automatic step();
      logic hit, can, gm;
      exp_t e;
      #2;
      hit = req_valid[m_ptr] | req_valid[~m_ptr];
      gm  = req_valid[m_ptr] ? m_ptr : ~m_ptr;
      can = ~m_vld | resp_ready;
      chk("req_ready", 32'(req_ready), (hit && can) ? 32'(2'b01 << gm) : 32'd0);
      chk("resp_valid", 32'(resp_valid), 32'(m_vld));
      if (m_vld) begin
         if (q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
         else begin
            e = resp_ready ? q.pop_front() : q[0];
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_result", 32'(resp_result), 32'(e.res));
            chk("resp_flags", 32'(resp_flags), 32'(e.flg));
         end
      end
      if (hit && can) begin
         q.push_back('{id: gm, res: exp_res[gm], flg: {exp_nv[gm], 4'b0}});
         m_ptr = ~gm;
      end
      m_vld = (hit && can) | (m_vld & ~resp_ready);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic one(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic r, input logic nv);
      set_req(0, 1'b1, op, a, b, r, nv);
      step();
   endtask

   initial begin
      set_req(0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      set_req(1, 1'b1, 2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_id", 32'(resp_id), 32'd0);
      chk("rst_resp_result", 32'(resp_result), 32'd0);
      chk("rst_resp_flags", 32'(resp_flags), 32'd0);
      req_valid = '0;
      rst = 1'b0;
      step();
      // Single FLT from requester 0, then directed edge cases back to back
      one(2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      one(2'b10, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0);
      one(2'b10, 32'h7F800001, 32'h3F800000, 1'b0, 1'b1);
      one(2'b00, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b1);
      one(2'b10, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
      one(2'b00, 32'hBF800000, 32'h3F800000, 1'b1, 1'b0);
      one(2'b11, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
      one(2'b11, 32'h7F800001, 32'h3F800000, 1'b0, 1'b0);
      one(2'b01, 32'hBF800000, 32'hC0000000, 1'b0, 1'b0);
      one(2'b01, 32'hC0000000, 32'hBF800000, 1'b1, 1'b0);
      one(2'b00, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
      one(2'b01, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
      one(2'b01, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
      one(2'b00, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
      one(2'b01, 32'h7F800000, 32'h7F7FFFFF, 1'b0, 1'b0);
      one(2'b00, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
      one(2'b01, 32'h3F800000, 32'hFFC00000, 1'b0, 1'b1);
      one(2'b10, 32'h3F800000, 32'h3F800000, 1'b1, 1'b0);
      set_req(0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0);
      step();
      // Both requesters continuously valid: grants alternate
      set_req(0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      set_req(1, 1'b1, 2'b00, 32'h40000000, 32'h3F800000, 1'b0, 1'b0);
      repeat (6) step();
      // Backpressure: response held, no grants, then pop+reload
      resp_ready = 1'b0;
      repeat (3) step();
      set_req(1, 1'b1, 2'b10, 32'h7F800001, 32'h7F800001, 1'b0, 1'b1);
      resp_ready = 1'b1;
      repeat (3) step();
      req_valid = '0;
      step();
      // Leave ptr at 1 and FULL, then async reset
      set_req(0, 1'b1, 2'b01, 32'h3F800000, 32'h40000000, 1'b1, 1'b0);
      resp_ready = 1'b0;
      step();
      req_valid = 2'b11;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_valid", 32'(resp_valid), 32'd0);
      chk("async_rst_ready", 32'(req_ready), 32'd0);
      chk("async_rst_id", 32'(resp_id), 32'd0);
      @(negedge clk);
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
      chk("rst_hold_valid", 32'(resp_valid), 32'd0);
      rst = 1'b0;
      resp_ready = 1'b1;
      m_vld = 1'b0;
      m_ptr = 1'b0;
      q.delete();
      set_req(1, 1'b1, 2'b10, 32'h00000000, 32'h80000000, 1'b1, 1'b0);
      step();
      req_valid = '0;
      step();
      step();
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
